// File: rtl/ps2_command_decoder.sv
// ps2_command_decoder: PS/2 keyboard receiver and scan-code to command-strobe
// decoder feeding sudoku_engine. Pins are synchronised, the clock line is
// glitch filtered, frames are checked for parity/stop/timeout, and E0/F0
// prefixes are tracked before mapping keys to one-cycle strobes.
// Optional build macro: PS2_KEYPAD_EN (numeric keypad also enters digits).
module ps2_command_decoder #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [3:0] cmd_number_o,
  output logic       cmd_up_o,
  output logic       cmd_down_o,
  output logic       cmd_left_o,
  output logic       cmd_right_o,
  output logic       cmd_enter_o,
  output logic       cmd_valid_o,
  output logic       rx_error_o,
  output logic [7:0] last_code_o
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

`ifdef PS2_KEYPAD_EN
  localparam logic [3:0] KP_2 = 4'd2;
  localparam logic [3:0] KP_4 = 4'd4;
  localparam logic [3:0] KP_6 = 4'd6;
  localparam logic [3:0] KP_8 = 4'd8;
  localparam logic [3:0] KP_1 = 4'd1;
  localparam logic [3:0] KP_3 = 4'd3;
  localparam logic [3:0] KP_5 = 4'd5;
  localparam logic [3:0] KP_7 = 4'd7;
  localparam logic [3:0] KP_9 = 4'd9;
`else
  localparam logic [3:0] KP_2 = 4'd0;
  localparam logic [3:0] KP_4 = 4'd0;
  localparam logic [3:0] KP_6 = 4'd0;
  localparam logic [3:0] KP_8 = 4'd0;
  localparam logic [3:0] KP_1 = 4'd0;
  localparam logic [3:0] KP_3 = 4'd0;
  localparam logic [3:0] KP_5 = 4'd0;
  localparam logic [3:0] KP_7 = 4'd0;
  localparam logic [3:0] KP_9 = 4'd0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  // Odd parity over data byte plus parity bit: good frames have an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          filt_q, filt_d, fall_s;
  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_d, good_d;
  logic          byte_valid_q;
  logic [7:0]    byte_q;
  logic          ext_q, ext_d, brk_q, brk_d;
  logic [3:0]    num_d;
  logic          up_d, down_d, left_d, right_d, enter_d, valid_d;

  // Two-flop synchronisers for both pins; idle line level is high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk_i;
      clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_data_i;
      dat_s2_q <= dat_s1_q;
    end
  end

  // Clock filter: flip only on the FILTER_LEN-th consecutive differing sample.
  always_comb begin
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall_s     = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_s2_q;
        fall_s = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end else begin
      filt_cnt_d = '0;
    end
  end

  // Receive FSM next state, advanced by filtered falling edges, with frame timeout.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    to_cnt_d  = to_cnt_q;
    err_d     = 1'b0;
    good_d    = 1'b0;
    if (fall_s) begin
      to_cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          state_d   = (bit_cnt_q == 3'd7) ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          par_d   = dat_s2_q;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          if (dat_s2_q && odd_parity_ok(shift_q, par_q)) begin
            good_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (to_cnt_q == TO_LAST) begin
        state_d  = ST_IDLE;
        err_d    = 1'b1;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end else begin
      to_cnt_d = '0;
    end
  end

  // Receiver state, filter and received-byte registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      filt_q       <= 1'b1;
      filt_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      par_q        <= 1'b0;
      to_cnt_q     <= '0;
      byte_valid_q <= 1'b0;
      byte_q       <= 8'h00;
      rx_error_o   <= 1'b0;
      last_code_o  <= 8'h00;
    end else begin
      filt_q       <= filt_d;
      filt_cnt_q   <= filt_cnt_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      to_cnt_q     <= to_cnt_d;
      byte_valid_q <= good_d;
      byte_q       <= good_d ? shift_q : byte_q;
      rx_error_o   <= err_d;
      last_code_o  <= good_d ? shift_q : last_code_o;
    end
  end

  // Prefix tracking and key map; errors drop any pending prefix.
  always_comb begin
    ext_d   = ext_q;
    brk_d   = brk_q;
    num_d   = 4'd0;
    up_d    = 1'b0;
    down_d  = 1'b0;
    left_d  = 1'b0;
    right_d = 1'b0;
    enter_d = 1'b0;
    if (err_d) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (byte_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        ext_d = 1'b0;
        brk_d = 1'b0;
      end else begin
        ext_d = 1'b0;
        case (byte_q)
          8'h16: num_d = 4'd1;
          8'h1E: num_d = 4'd2;
          8'h26: num_d = 4'd3;
          8'h25: num_d = 4'd4;
          8'h2E: num_d = 4'd5;
          8'h36: num_d = 4'd6;
          8'h3D: num_d = 4'd7;
          8'h3E: num_d = 4'd8;
          8'h46: num_d = 4'd9;
          8'h75: begin up_d    = ext_q; num_d = ext_q ? 4'd0 : KP_8; end
          8'h72: begin down_d  = ext_q; num_d = ext_q ? 4'd0 : KP_2; end
          8'h6B: begin left_d  = ext_q; num_d = ext_q ? 4'd0 : KP_4; end
          8'h74: begin right_d = ext_q; num_d = ext_q ? 4'd0 : KP_6; end
          8'h69: num_d = ext_q ? 4'd0 : KP_1;
          8'h7A: num_d = ext_q ? 4'd0 : KP_3;
          8'h73: num_d = ext_q ? 4'd0 : KP_5;
          8'h6C: num_d = ext_q ? 4'd0 : KP_7;
          8'h7D: num_d = ext_q ? 4'd0 : KP_9;
          8'h1D: up_d    = !ext_q;
          8'h1B: down_d  = !ext_q;
          8'h1C: left_d  = !ext_q;
          8'h23: right_d = !ext_q;
          8'h5A: enter_d = 1'b1;
          default: num_d = 4'd0;
        endcase
      end
    end else begin
      ext_d = ext_q;
      brk_d = brk_q;
    end
    valid_d = (num_d != 4'd0) | up_d | down_d | left_d | right_d | enter_d;
  end

  // Prefix flags and registered one-cycle command strobes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      cmd_number_o <= 4'd0;
      cmd_up_o     <= 1'b0;
      cmd_down_o   <= 1'b0;
      cmd_left_o   <= 1'b0;
      cmd_right_o  <= 1'b0;
      cmd_enter_o  <= 1'b0;
      cmd_valid_o  <= 1'b0;
    end else begin
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      cmd_number_o <= num_d;
      cmd_up_o     <= up_d;
      cmd_down_o   <= down_d;
      cmd_left_o   <= left_d;
      cmd_right_o  <= right_d;
      cmd_enter_o  <= enter_d;
      cmd_valid_o  <= valid_d;
    end
  end

endmodule

// File: tb/tb_ps2_command_decoder.sv
// Self-checking bench for ps2_command_decoder: vector table, hand-written
// multi-cycle corner cases, and randomized frames against a key-map model.
// Honors PS2_KEYPAD_EN in the same way as the design.
module tb_ps2_command_decoder;

  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 20;
  localparam int GAP  = 30;

`ifdef PS2_KEYPAD_EN
  localparam bit KEYPAD = 1'b1;
`else
  localparam bit KEYPAD = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       ps2_clk, ps2_data;
  logic [3:0] cmd_number;
  logic       cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, cmd_valid;
  logic       rx_error;
  logic [7:0] last_code;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;
  logic [7:0] exp_last = 8'h00;
  bit m_ext = 1'b0, m_brk = 1'b0;

  ps2_command_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .reset_i(reset), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
    .cmd_number_o(cmd_number), .cmd_up_o(cmd_up), .cmd_down_o(cmd_down),
    .cmd_left_o(cmd_left), .cmd_right_o(cmd_right), .cmd_enter_o(cmd_enter),
    .cmd_valid_o(cmd_valid), .rx_error_o(rx_error), .last_code_o(last_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe/error pulse counter and field consistency monitor.
  always @(negedge clk) begin
    int nz;
    if (!reset) begin
      nz = int'(cmd_number != 4'd0) + int'(cmd_up) + int'(cmd_down) + int'(cmd_left)
         + int'(cmd_right) + int'(cmd_enter);
      strobe_cnt += int'(cmd_valid);
      err_cnt    += int'(rx_error);
      if (cmd_valid) check("onehot_fields", nz, 1);
      else if (nz != 0) check("fields_without_valid", nz, 0);
    end
  end

  // Reference key map: lookup lists, dirs = {up,down,left,right,enter}.
  task automatic ref_map(input logic [7:0] code, input bit ext,
                         output logic [3:0] num, output logic [4:0] dirs);
    logic [7:0] digits [9] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] keypad [9] = '{8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
    logic [7:0] arrows [4] = '{8'h75, 8'h72, 8'h6B, 8'h74};
    logic [7:0] wasd   [4] = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
    num = 4'd0;
    dirs = 5'b0;
    for (int i = 0; i < 9; i++) begin
      if (digits[i] == code) num = 4'(i + 1);
      if (KEYPAD && !ext && keypad[i] == code) num = 4'(i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      if (ext && arrows[i] == code) dirs[4-i] = 1'b1;
      if (!ext && wasd[i] == code) dirs[4-i] = 1'b1;
    end
    if (code == 8'h5A) dirs[0] = 1'b1;
  endtask

  // Model of prefix handling for one received frame.
  task automatic model_frame(input logic [7:0] code, input bit is_err,
                             output logic [3:0] num, output logic [4:0] dirs);
    num = 4'd0;
    dirs = 5'b0;
    if (is_err) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else if (code == 8'hE0) m_ext = 1'b1;
    else if (code == 8'hF0) m_brk = 1'b1;
    else if (m_brk) begin
      m_ext = 1'b0; m_brk = 1'b0;
    end else begin
      ref_map(code, m_ext, num, dirs);
      m_ext = 1'b0;
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop);
    return {~bad_stop, ~(^code) ^ bad_par, code, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                            input logic [3:0] e_num, input logic [4:0] e_dirs, input string tag);
    logic [10:0] f;
    bit e_err, e_valid;
    int s0, r0;
    f = make_frame(code, bad_par, bad_stop);
    e_err = bad_par | bad_stop;
    e_valid = (e_num != 4'd0) || (e_dirs != 5'b0);
    for (int i = 0; i < 10; i++) drive_bit(f[i]);
    @(negedge clk);
    ps2_data = f[10];
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    s0 = strobe_cnt;
    r0 = err_cnt;
    repeat (FL + 2) @(negedge clk);
    check({tag, "_rx_error"}, rx_error, e_err);
    check({tag, "_early_valid"}, cmd_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, cmd_valid, e_valid);
    check({tag, "_number"}, cmd_number, e_num);
    check({tag, "_dirs"}, {cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter}, e_dirs);
    repeat (HALF - FL - 3) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
    check({tag, "_strobe_count"}, strobe_cnt - s0, e_valid);
    check({tag, "_error_count"}, err_cnt - r0, e_err);
    if (!e_err) exp_last = code;
    check({tag, "_last_code"}, last_code, exp_last);
  endtask

  typedef struct {
    logic [7:0] code;
    bit         e0;
    logic [3:0] num;
    logic [4:0] dirs;
  } vec_t;

  initial begin
    vec_t vecs[$];
    logic [7:0] pool [12] = '{8'h16, 8'h46, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h23, 8'h5A, 8'h73, 8'h69, 8'h2E};
    logic [3:0] rn;
    logic [4:0] rd;
    int s0, r0;
    logic [10:0] f;

    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_valid", cmd_valid, 1'b0);
    check("reset_error", rx_error, 1'b0);
    check("reset_last_code", last_code, 8'h00);
    check("reset_number", cmd_number, 4'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    vecs.push_back('{8'h16, 1'b0, 4'd1, 5'b00000});
    vecs.push_back('{8'h46, 1'b0, 4'd9, 5'b00000});
    vecs.push_back('{8'h3D, 1'b1, 4'd7, 5'b00000});
    vecs.push_back('{8'h75, 1'b1, 4'd0, 5'b10000});
    vecs.push_back('{8'h72, 1'b1, 4'd0, 5'b01000});
    vecs.push_back('{8'h6B, 1'b1, 4'd0, 5'b00100});
    vecs.push_back('{8'h74, 1'b1, 4'd0, 5'b00010});
    vecs.push_back('{8'h1D, 1'b0, 4'd0, 5'b10000});
    vecs.push_back('{8'h1B, 1'b0, 4'd0, 5'b01000});
    vecs.push_back('{8'h1C, 1'b0, 4'd0, 5'b00100});
    vecs.push_back('{8'h23, 1'b0, 4'd0, 5'b00010});
    vecs.push_back('{8'h5A, 1'b0, 4'd0, 5'b00001});
    vecs.push_back('{8'h5A, 1'b1, 4'd0, 5'b00001});
    vecs.push_back('{8'h1D, 1'b1, 4'd0, 5'b00000});
    vecs.push_back('{8'h00, 1'b0, 4'd0, 5'b00000});
    vecs.push_back('{8'h73, 1'b0, KEYPAD ? 4'd5 : 4'd0, 5'b00000});
    vecs.push_back('{8'h72, 1'b0, KEYPAD ? 4'd2 : 4'd0, 5'b00000});
    vecs.push_back('{8'h75, 1'b0, KEYPAD ? 4'd8 : 4'd0, 5'b00000});
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].e0) send_frame(8'hE0, 1'b0, 1'b0, 4'd0, 5'b0, "vec_prefix");
      send_frame(vecs[i].code, 1'b0, 1'b0, vecs[i].num, vecs[i].dirs, $sformatf("vec%0d", i));
    end

    // Break sequence then a make; typematic repeat gives a second strobe.
    send_frame(8'hE0, 1'b0, 1'b0, 4'd0, 5'b0, "brk_e0");
    send_frame(8'hF0, 1'b0, 1'b0, 4'd0, 5'b0, "brk_f0");
    send_frame(8'h75, 1'b0, 1'b0, 4'd0, 5'b0, "brk_75");
    send_frame(8'h16, 1'b0, 1'b0, 4'd1, 5'b0, "after_brk");
    send_frame(8'h16, 1'b0, 1'b0, 4'd1, 5'b0, "repeat");

    // Errors drop pending prefixes; bad parity leaves last_code alone.
    send_frame(8'hF0, 1'b0, 1'b0, 4'd0, 5'b0, "err_f0");
    send_frame(8'h5A, 1'b1, 1'b0, 4'd0, 5'b0, "bad_parity");
    send_frame(8'h16, 1'b0, 1'b0, 4'd1, 5'b0, "brk_cleared");
    send_frame(8'hE0, 1'b0, 1'b0, 4'd0, 5'b0, "err_e0");
    send_frame(8'h1C, 1'b0, 1'b1, 4'd0, 5'b0, "bad_stop");
    send_frame(8'h1D, 1'b0, 1'b0, 4'd0, 5'b10000, "ext_cleared");

    // Partial frame then silence: timeout error, then a clean frame.
    f = make_frame(8'h00, 1'b0, 1'b0);
    s0 = strobe_cnt; r0 = err_cnt;
    for (int i = 0; i < 4; i++) drive_bit(f[i]);
    ps2_data = 1'b1;
    repeat (TO + FL + 20) @(negedge clk);
    check("timeout_error_count", err_cnt - r0, 1);
    check("timeout_strobe_count", strobe_cnt - s0, 0);
    send_frame(8'h1D, 1'b0, 1'b0, 4'd0, 5'b10000, "after_timeout");

    // Short low glitch on the clock line must not start a frame.
    s0 = strobe_cnt; r0 = err_cnt;
    @(negedge clk); ps2_data = 1'b0; ps2_clk = 1'b0;
    repeat (3) @(negedge clk);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (TO + 40) @(negedge clk);
    check("glitch_error_count", err_cnt - r0, 0);
    check("glitch_strobe_count", strobe_cnt - s0, 0);
    send_frame(8'h1E, 1'b0, 1'b0, 4'd2, 5'b0, "after_glitch");

    // Asynchronous reset mid-frame.
    f = make_frame(8'h16, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) drive_bit(f[i]);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_rst_last_code", last_code, 8'h00);
    check("async_rst_outputs", {cmd_valid, cmd_number, rx_error}, 6'd0);
    exp_last = 8'h00;
    m_ext = 1'b0; m_brk = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = strobe_cnt;
    for (int i = 6; i < 11; i++) drive_bit(f[i]);
    ps2_data = 1'b1;
    repeat (TO + 60) @(negedge clk);
    check("rst_tail_strobe_count", strobe_cnt - s0, 0);
    send_frame(8'h1E, 1'b0, 1'b0, 4'd2, 5'b0, "after_reset");

    // Randomized frames against the reference model.
    m_ext = 1'b0; m_brk = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic [7:0] code;
      bit bp, bs;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 2) code = 8'hE0;
      else if (sel < 3) code = 8'hF0;
      else if (sel < 4) code = 8'($urandom_range(0, 255));
      else code = pool[$urandom_range(0, 11)];
      bp = ($urandom_range(0, 9) == 0);
      bs = !bp && ($urandom_range(0, 19) == 0);
      model_frame(code, bp | bs, rn, rd);
      send_frame(code, bp, bs, rn, rd, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/ps2_command_decoder.md
# ps2_command_decoder

Receives PS/2 keyboard frames and converts scan codes into the one-cycle command strobes consumed by `sudoku_engine`: `cmd_number`, `cmd_up`, `cmd_down`, `cmd_left`, `cmd_right`, `cmd_enter` and `cmd_valid`. It sits between the keyboard pins and the engine, replacing pushbutton and switch entry. It handles pin synchronisation, clock-line glitch filtering, frame reception with parity and timeout checking, and E0/F0 prefix tracking.

## Interface
- `FILTER_LEN`, default 8: consecutive equal samples required before the filtered PS/2 clock changes level.
- `TIMEOUT_CYCLES`, default 100000: maximum `clk` cycles allowed between filtered PS/2 clock falling edges inside a frame.
- `clk`  in  1  system clock; every register is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk`  in  1  raw keyboard clock pin (asynchronous).
- `ps2_data`  in  1  raw keyboard data pin (asynchronous).
- `cmd_number`  out  4  digit 1–9 during a number strobe; 0 at all other times.
- `cmd_up` / `cmd_down` / `cmd_left` / `cmd_right` / `cmd_enter`  out  1 each  command strobes.
- `cmd_valid`  out  1  one-cycle qualifier; exactly one command field is non-zero in the same cycle.
- `rx_error`  out  1  one-cycle pulse on a parity, stop-bit or timeout error.
- `last_code`  out  8  last correctly received byte (debug); holds its value between frames.

## Operation
- **Input conditioning**
  - Both pins pass through 2-flop synchronisers.
  - The synchronised clock feeds a saturating counter filter; the filtered level flips only after `FILTER_LEN` consecutive samples that differ from it.
  - A falling edge of the filtered clock samples the synchronised data.
- **Receive FSM** (advances only on filtered falling edges)
  - `IDLE`: data=0 moves to `DATA` with the bit count cleared. Data=1 is a bad start bit: the FSM stays in `IDLE` and raises no error.
  - `DATA`: shifts 8 bits in LSB first. After bit 8 it moves to `PARITY`.
  - `PARITY`: captures the bit and moves to `STOP`.
  - `STOP`: if stop=1 and the 9 bits (data plus parity) have odd parity, the byte is good. Otherwise `rx_error` pulses. Either way the FSM returns to `IDLE`.
  - Timeout: in any non-`IDLE` state, the timeout counter resets on each edge. When it reaches `TIMEOUT_CYCLES-1`, the FSM goes to `IDLE` and `rx_error` pulses.
- **Byte decoder** (runs on each good byte; holds `ext` and `brk` flags)
  - 0xE0 sets `ext`. 0xF0 sets `brk`. Neither produces a strobe.
  - Any other byte with `brk`=1: clear both flags, no strobe (key release).
  - Any other byte with `brk`=0: map the byte as below, then clear `ext`.
- **Key map**
  - Top-row digits: 0x16, 0x1E, 0x26, 0x25, 0x2E, 0x36, 0x3D, 0x3E, 0x46 give numbers 1–9 (E0 prefix ignored).
  - Arrows with `ext`=1: 0x75 up, 0x72 down, 0x6B left, 0x74 right.
  - WASD with `ext`=0: 0x1D up, 0x1B down, 0x1C left, 0x23 right.
  - Enter: 0x5A, with or without E0.
  - Unmapped codes produce no strobe.
- **Repeat and errors**
  - Typematic repeats of a make code each produce a new strobe.
  - Any error clears `ext` and `brk`.
- **Reset values:** every output is 0, `last_code` is 0x00, the FSM is in `IDLE`, the flags are clear, and the filtered clock is 1. Reset asserted mid-frame discards the partial frame and emits no strobe.

## Timing
- **Strobe latency:** `cmd_valid` and its command field assert exactly 2 `clk` cycles after the cycle in which the filtered stop-bit falling edge is detected.
- **Error latency:** `rx_error` asserts 1 cycle after the failing edge or timeout.
- **Pin-to-edge delay:** 2 + `FILTER_LEN` cycles.
- **Register outputs:** all outputs are registered, and strobes are exactly 1 cycle wide.
- **Strobe spacing:** at most one strobe per frame (~1 ms), so strobes are never back-to-back and the engine needs no backpressure.
- **Filter reject:** a clock glitch shorter than `FILTER_LEN` cycles produces no edge.

## Configuration
- Macro: `PS2_KEYPAD_EN`.
- **Defined:** with `ext`=0, the numeric keypad also maps to digits: 0x69→1, 0x72→2, 0x7A→3, 0x6B→4, 0x73→5, 0x74→6, 0x6C→7, 0x75→8, 0x7D→9. This does not conflict with the arrow keys, which require `ext`=1.
- **Undefined:** keypad codes are unmapped and produce no strobe.

## Test plan
- Frame 0x16 with correct parity → `cmd_valid`=1 and `cmd_number`=1 for one cycle, 2 cycles after the stop edge; `last_code`=0x16.
- Frames E0, 75 → a single `cmd_up` strobe; frames E0, F0, 75 → no strobe, flags clear afterwards.
- Frame 0x5A with bad parity → `rx_error` pulse, no `cmd_enter`; `last_code` unchanged.
- 4 bits of a frame, then idle for `TIMEOUT_CYCLES` → `rx_error` pulse, FSM in `IDLE`; a following 0x1D frame → `cmd_up`.
- Frame 0x73: with `PS2_KEYPAD_EN`, `cmd_number`=5; without it, no strobe. A 3-cycle low glitch on `ps2_clk` (`FILTER_LEN`=8) → no state change.
- Async `reset` pulse after bit 5 of 0x16 → all outputs 0 immediately; the remaining bits produce no strobe; the next full 0x1E frame → `cmd_number`=2.
